lsb_mem_port: RTL



---
 rtl/lsb_pkg.sv | 37 +++
 rtl/lsb_extend.sv | 21 ++
 rtl/lsb_mem_port.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lsb_pkg.sv
// lsb_pkg: shared encodings for the load/store byte channel.
// Size codes, the port state machine states, the default IO window base
// and small helpers shared by the port and the writeback path.
package lsb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] IO_ADDR_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Number of bytes moved for a size code; the reserved code 3 moves a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // True when a half or word does not start on its natural boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic [2:0] n;
    n = size_bytes(size);
    return ((n == 3'd2) && addr_lo[0]) || ((n == 3'd4) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsb_extend.sv
// lsb_extend: size-based sign/zero extension of an assembled little-endian
// word. Purely combinational so the writeback path can reuse it.
module lsb_extend
  import lsb_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  // Replicate the top bit of the loaded quantity (or zero) into the upper bits.
  always_comb begin
    case (size)
      SZ_BYTE: result = {{24{is_signed & data[7]}}, data[7:0]};
      SZ_HALF: result = {{16{is_signed & data[15]}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/lsb_mem_port.sv
// lsb_mem_port: initiator side of the load/store byte channel into
// mem_controller. Splits one 1/2/4-byte load or store into single-byte
// accesses, reassembles load data and pulses a one-cycle response.
// Optional build macro LSB_MISALIGN_CHECK_EN: misaligned halves/words are
// rejected without touching memory and flagged on misaligned_out.
module lsb_mem_port
  import lsb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = ADDR_WIDTH'(IO_ADDR_BASE_DEFAULT)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [1:0]            req_size_in,
  input  logic                  req_signed_in,
  input  logic                  req_wr_in,
  input  logic [31:0]           req_wdata_in,
  input  logic                  flush_in,
  input  logic                  io_buffer_full_in,
  output logic                  resp_valid_out,
  output logic [31:0]           resp_data_out,
`ifdef LSB_MISALIGN_CHECK_EN
  output logic                  misaligned_out,
`endif
  output logic [ADDR_WIDTH-1:0] lsb_addr_out,
  output logic [7:0]            lsb_data_out,
  output logic                  lsb_wr_out,
  output logic                  lsb_valid_out,
  input  logic                  lsb_done_in,
  input  logic [7:0]            lsb_read_data_in
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [2:0]            nbytes_q;
  logic [2:0]            k_q;
  logic                  sign_q;
  logic                  wr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           asm_q;
  logic [31:0]           resp_data_q;
  logic                  cap_pending_q;
`ifdef LSB_MISALIGN_CHECK_EN
  logic                  mis_q;
`endif

  logic [ADDR_WIDTH-1:0] byte_addr;
  logic                  io_stall;
  logic                  xfer_valid;
  logic                  accept_byte;
  logic                  last_byte;
  logic [1:0]            cap_idx;
  logic [31:0]           asm_next;
  logic [31:0]           ext_data;

  assign byte_addr   = addr_q + ADDR_WIDTH'(k_q);
  assign io_stall    = wr_q && (byte_addr >= IO_ADDR_BASE) && io_buffer_full_in;
  assign xfer_valid  = (state == XFER) && !io_stall;
  assign accept_byte = xfer_valid && lsb_done_in;
  assign last_byte   = (k_q == (nbytes_q - 3'd1));
  assign cap_idx     = 2'(k_q - 3'd1);

  // Merge the read byte returned one cycle after its address was accepted.
  always_comb begin
    asm_next = asm_q;
    if (cap_pending_q) begin
      asm_next[{cap_idx, 3'b000} +: 8] = lsb_read_data_in;
    end
  end

  lsb_extend u_extend (
    .data      (asm_next),
    .size      (size_q),
    .is_signed (sign_q),
    .result    (ext_data)
  );

  assign req_ready_out  = (state == IDLE);
  assign lsb_valid_out  = xfer_valid;
  assign lsb_addr_out   = (state == XFER) ? byte_addr : '0;
  assign lsb_wr_out     = (state == XFER) && wr_q;
  assign lsb_data_out   = ((state == XFER) && wr_q) ? wdata_q[{k_q[1:0], 3'b000} +: 8] : 8'h00;
  assign resp_valid_out = (state == RESP) && !(flush_in && !wr_q);
  assign resp_data_out  = resp_data_q;
`ifdef LSB_MISALIGN_CHECK_EN
  assign misaligned_out = resp_valid_out && mis_q;
`endif

  // Request sequencing: accept, walk the bytes, drain the last read, respond.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      addr_q        <= '0;
      size_q        <= SZ_BYTE;
      nbytes_q      <= 3'd1;
      k_q           <= 3'd0;
      sign_q        <= 1'b0;
      wr_q          <= 1'b0;
      wdata_q       <= 32'h0;
      asm_q         <= 32'h0;
      resp_data_q   <= 32'h0;
      cap_pending_q <= 1'b0;
`ifdef LSB_MISALIGN_CHECK_EN
      mis_q         <= 1'b0;
`endif
    end else begin
      cap_pending_q <= 1'b0;
      asm_q         <= asm_next;
      case (state)
        IDLE: begin
          if (req_valid_in && !flush_in) begin
            addr_q   <= req_addr_in;
            size_q   <= req_size_in;
            nbytes_q <= size_bytes(req_size_in);
            sign_q   <= req_signed_in;
            wr_q     <= req_wr_in;
            wdata_q  <= req_wdata_in;
            k_q      <= 3'd0;
            asm_q    <= 32'h0;
`ifdef LSB_MISALIGN_CHECK_EN
            mis_q    <= is_misaligned(req_addr_in[1:0], req_size_in);
            if (is_misaligned(req_addr_in[1:0], req_size_in)) begin
              resp_data_q <= 32'h0;
              state       <= RESP;
            end else begin
              state       <= XFER;
            end
`else
            state    <= XFER;
`endif
          end
        end
        XFER: begin
          if (flush_in && !wr_q) begin
            state <= IDLE;
          end else if (accept_byte) begin
            k_q           <= k_q + 3'd1;
            cap_pending_q <= !wr_q;
            if (last_byte) begin
              if (wr_q) begin
                resp_data_q <= 32'h0;
                state       <= RESP;
              end else begin
                state       <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (flush_in) begin
            state <= IDLE;
          end else begin
            resp_data_q <= ext_data;
            state       <= RESP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
